// File: rtl/sample_iter_param.sv
// Bounding-box sample iterator: latches one micropolygon with its box and walks
// every subsample position inside the box in raster order, one per handshake.
module sample_iter_param #(
    parameter int SIGFIG       = 24,
    parameter int RADIX        = 10,
    parameter int VERTS        = 3,
    parameter int AXIS         = 3,
    parameter int COLORS       = 3,
    parameter int MAX_SS_SHIFT = 3,
    parameter int SSW          = $clog2(MAX_SS_SHIFT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [VERTS*AXIS*SIGFIG-1:0]   poly_in,
    input  logic [COLORS*SIGFIG-1:0]       color_in,
    input  logic [SIGFIG-1:0]              box_ll_x_in,
    input  logic [SIGFIG-1:0]              box_ll_y_in,
    input  logic [SIGFIG-1:0]              box_ur_x_in,
    input  logic [SIGFIG-1:0]              box_ur_y_in,
    input  logic [SSW-1:0]                 ss_shift_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SIGFIG-1:0]              sample_x_out,
    output logic [SIGFIG-1:0]              sample_y_out,
    output logic [VERTS*AXIS*SIGFIG-1:0]   poly_out,
    output logic [COLORS*SIGFIG-1:0]       color_out,
    output logic                           last_out
);
    localparam int PW = VERTS * AXIS * SIGFIG;
    localparam int CW = COLORS * SIGFIG;
    localparam logic [SIGFIG-1:0] ONE_PIX = SIGFIG'(1) << RADIX;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    // True when pos+step lands beyond ur; one extra bit keeps the sum from wrapping.
    function automatic logic beyond(input logic [SIGFIG-1:0] pos,
                                    input logic [SIGFIG-1:0] step,
                                    input logic [SIGFIG-1:0] ur);
        logic signed [SIGFIG:0] sum_v;
        sum_v = $signed({pos[SIGFIG-1], pos}) + $signed({1'b0, step});
        return sum_v > $signed({ur[SIGFIG-1], ur});
    endfunction

    state_t              state_r, state_n;
    logic                out_valid_r, out_valid_n;
    logic                last_r, last_n;
    logic [SIGFIG-1:0]   sample_x_r, sample_x_n, sample_y_r, sample_y_n;
    logic [SIGFIG-1:0]   ll_x_r, ll_x_n, ur_x_r, ur_x_n, ur_y_r, ur_y_n;
    logic [SIGFIG-1:0]   step_r, step_n;
    logic [PW-1:0]       poly_r, poly_n;
    logic [CW-1:0]       color_r, color_n;

    logic [SSW-1:0]      shift_s;
    logic [SIGFIG-1:0]   step_in_s, snap_x_s, snap_y_s;
    logic                degenerate_s, first_last_s, accept_s;
    logic                wrap_s, adv_last_s;
    logic [SIGFIG-1:0]   adv_x_s, adv_y_s;

    assign in_ready = (state_r == IDLE) && !rst;
    assign accept_s = in_valid && in_ready;

    // Clamp the requested subsample shift to the supported range.
    always_comb begin
        shift_s = ss_shift_in;
        if (int'(ss_shift_in) > MAX_SS_SHIFT) begin
            shift_s = SSW'(MAX_SS_SHIFT);
        end else begin
            shift_s = ss_shift_in;
        end
    end

    // Incoming box: step size, lower-left snapped down onto the step grid, and box classification.
    always_comb begin
        step_in_s    = ONE_PIX >> shift_s;
        snap_x_s     = box_ll_x_in & ~(step_in_s - SIGFIG'(1));
        snap_y_s     = box_ll_y_in & ~(step_in_s - SIGFIG'(1));
        degenerate_s = ($signed(box_ur_x_in) < $signed(snap_x_s)) ||
                       ($signed(box_ur_y_in) < $signed(snap_y_s));
        first_last_s = beyond(snap_x_s, step_in_s, box_ur_x_in) &&
                       beyond(snap_y_s, step_in_s, box_ur_y_in);
    end

    // Raster-order successor of the current sample and whether it is the final one.
    always_comb begin
        wrap_s     = beyond(sample_x_r, step_r, ur_x_r);
        adv_x_s    = wrap_s ? ll_x_r : sample_x_r + step_r;
        adv_y_s    = wrap_s ? sample_y_r + step_r : sample_y_r;
        adv_last_s = beyond(adv_x_s, step_r, ur_x_r) && beyond(adv_y_s, step_r, ur_y_r);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state_r;
        out_valid_n = out_valid_r;
        last_n      = last_r;
        sample_x_n  = sample_x_r;
        sample_y_n  = sample_y_r;
        ll_x_n      = ll_x_r;
        ur_x_n      = ur_x_r;
        ur_y_n      = ur_y_r;
        step_n      = step_r;
        poly_n      = poly_r;
        color_n     = color_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !degenerate_s) begin
                    state_n     = ITER;
                    out_valid_n = 1'b1;
                    last_n      = first_last_s;
                    sample_x_n  = snap_x_s;
                    sample_y_n  = snap_y_s;
                    ll_x_n      = snap_x_s;
                    ur_x_n      = box_ur_x_in;
                    ur_y_n      = box_ur_y_in;
                    step_n      = step_in_s;
                    poly_n      = poly_in;
                    color_n     = color_in;
                end else begin
                    state_n = IDLE;
                end
            end
            ITER: begin
                if (out_ready && last_r) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                    last_n      = 1'b0;
                end else if (out_ready) begin
                    sample_x_n = adv_x_s;
                    sample_y_n = adv_y_s;
                    last_n     = adv_last_s;
                end else begin
                    state_n = ITER;
                end
            end
            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
                last_n      = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight polygon.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
            sample_x_r  <= '0;
            sample_y_r  <= '0;
            ll_x_r      <= '0;
            ur_x_r      <= '0;
            ur_y_r      <= '0;
            step_r      <= '0;
            poly_r      <= '0;
            color_r     <= '0;
        end else begin
            state_r     <= state_n;
            out_valid_r <= out_valid_n;
            last_r      <= last_n;
            sample_x_r  <= sample_x_n;
            sample_y_r  <= sample_y_n;
            ll_x_r      <= ll_x_n;
            ur_x_r      <= ur_x_n;
            ur_y_r      <= ur_y_n;
            step_r      <= step_n;
            poly_r      <= poly_n;
            color_r     <= color_n;
        end
    end

    assign out_valid    = out_valid_r;
    assign last_out     = last_r;
    assign sample_x_out = sample_x_r;
    assign sample_y_out = sample_y_r;
    assign poly_out     = poly_r;
    assign color_out    = color_r;

endmodule

// File: tb/tb_sample_iter_param.sv
// Bench for sample_iter_param: directed vector table, reset/backpressure sequences,
// and randomized boxes checked against a plain-arithmetic sample-list model.
module tb_sample_iter_param;
    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int MAXSH  = 3;
    localparam int SSW    = 2;
    localparam int PW     = VERTS * AXIS * SIGFIG;
    localparam int CW     = COLORS * SIGFIG;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PW-1:0]     poly_in = '0;
    logic [CW-1:0]     color_in = '0;
    logic [SIGFIG-1:0] box_ll_x_in = '0, box_ll_y_in = '0, box_ur_x_in = '0, box_ur_y_in = '0;
    logic [SSW-1:0]    ss_shift_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [SIGFIG-1:0] sample_x_out, sample_y_out;
    logic [PW-1:0]     poly_out;
    logic [CW-1:0]     color_out;
    logic              last_out;

    int errors = 0;
    int checks = 0;

    sample_iter_param #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS),
        .COLORS(COLORS), .MAX_SS_SHIFT(MAXSH), .SSW(SSW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .poly_in(poly_in), .color_in(color_in),
        .box_ll_x_in(box_ll_x_in), .box_ll_y_in(box_ll_y_in),
        .box_ur_x_in(box_ur_x_in), .box_ur_y_in(box_ur_y_in),
        .ss_shift_in(ss_shift_in), .out_valid(out_valid), .out_ready(out_ready),
        .sample_x_out(sample_x_out), .sample_y_out(sample_y_out),
        .poly_out(poly_out), .color_out(color_out), .last_out(last_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int llx, lly, urx, ury, sh, mode;
        int n, fx, fy, lx, ly;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int floor_to(input int v, input int s);
        if (v >= 0) return (v / s) * s;
        else return -(((-v) + s - 1) / s) * s;
    endfunction

    function automatic int sx();
        return int'($signed(sample_x_out));
    endfunction

    function automatic int sy();
        return int'($signed(sample_y_out));
    endfunction

    // Offer one polygon, returning at the falling edge just after it is accepted.
    task automatic drive(input int llx, lly, urx, ury, sh,
                         input logic [PW-1:0] p, input logic [CW-1:0] c);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", int'(in_ready), 1);
        poly_in     = p;
        color_in    = c;
        box_ll_x_in = 24'(llx);
        box_ll_y_in = 24'(lly);
        box_ur_x_in = 24'(urx);
        box_ur_y_in = 24'(ury);
        ss_shift_in = 2'(sh);
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
        poly_in     = '0;
        color_in    = '0;
    endtask

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall on the 3rd sample.
    task automatic run_poly(input int llx, lly, urx, ury, sh, mode,
                            output int cnt, fx, fy, lx, ly);
        int ex[$], ey[$];
        int st, snx, sny, n, idx, cyc, stall_left, px, py, pl;
        logic rdy, prev_rdy, done;
        logic [PW-1:0] p, pp;
        logic [CW-1:0] c;
        logic [223:0] t;
        logic [95:0] tc;
        t  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        tc = {$urandom(), $urandom(), $urandom()};
        p  = t[PW-1:0];
        c  = tc[CW-1:0];
        st  = 1024 >> ((sh > MAXSH) ? MAXSH : sh);
        snx = floor_to(llx, st);
        sny = floor_to(lly, st);
        if (urx >= snx && ury >= sny) begin
            for (int y = sny; y <= ury; y += st)
                for (int x = snx; x <= urx; x += st) begin
                    ex.push_back(x);
                    ey.push_back(y);
                end
        end
        n = ex.size();
        cnt = 0; fx = 0; fy = 0; lx = 0; ly = 0;
        drive(llx, lly, urx, ury, sh, p, c);
        if (n == 0) begin
            for (int k = 0; k < 3; k++) begin
                chk("degen_valid", int'(out_valid), 0);
                chk("degen_ready", int'(in_ready), 1);
                @(negedge clk);
            end
            return;
        end
        idx = 0; cyc = 0; done = 1'b0; prev_rdy = 1'b1;
        stall_left = (mode == 2) ? 5 : 0;
        px = 0; py = 0; pl = 0; pp = '0;
        while (!done && cyc < 4000) begin
            chk("valid", int'(out_valid), 1);
            chk("ready_busy", int'(in_ready), 0);
            if (!prev_rdy) begin
                chk("hold_x", sx(), px);
                chk("hold_y", sy(), py);
                chk("hold_last", int'(last_out), pl);
                chk_w("hold_poly", poly_out, pp);
            end
            chk("sample_x", sx(), ex[idx]);
            chk("sample_y", sy(), ey[idx]);
            chk("last", int'(last_out), (idx == n - 1) ? 1 : 0);
            chk_w("poly", poly_out, p);
            chk_w("color", PW'(color_out), PW'(c));
            if (idx == 0) begin
                fx = sx();
                fy = sy();
            end
            lx = sx();
            ly = sy();
            if (mode == 2 && idx == 2 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if (mode == 1) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            px = sx(); py = sy(); pl = int'(last_out); pp = poly_out;
            prev_rdy  = rdy;
            out_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) begin
                if (idx == n - 1) done = 1'b1;
                idx++;
            end
        end
        out_ready = 1'b0;
        if (!done) begin
            chk("timeout", 0, 1);
        end else begin
            chk("end_valid", int'(out_valid), 0);
            chk("end_last", int'(last_out), 0);
            chk("end_ready", int'(in_ready), 1);
        end
        cnt = idx;
    endtask

    vec_t vecs[7];

    initial begin
        int cnt, fx, fy, lx, ly;
        int llx, lly, urx, ury;
        vecs[0] = '{0, 0, 2048, 1024, 0, 0, 6, 0, 0, 2048, 1024};
        vecs[1] = '{700, 0, 1024, 0, 1, 0, 2, 512, 0, 1024, 0};
        vecs[2] = '{3072, 3072, 3072, 3072, 0, 0, 1, 3072, 3072, 3072, 3072};
        vecs[3] = '{2048, 0, 1024, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{-300, -256, 0, -256, 2, 0, 3, -512, -256, 0, -256};
        vecs[5] = '{0, 0, 3072, 1024, 0, 2, 8, 0, 0, 3072, 1024};
        vecs[6] = '{-1, -1, 0, 0, 3, 1, 4, -128, -128, 0, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_last", int'(last_out), 0);
        chk("rst_x", sx(), 0);
        chk("rst_y", sy(), 0);
        chk_w("rst_poly", poly_out, '0);
        chk_w("rst_color", PW'(color_out), '0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", int'(in_ready), 1);
        @(negedge clk);

        foreach (vecs[i]) begin
            run_poly(vecs[i].llx, vecs[i].lly, vecs[i].urx, vecs[i].ury,
                     vecs[i].sh, vecs[i].mode, cnt, fx, fy, lx, ly);
            chk($sformatf("vec%0d_count", i), cnt, vecs[i].n);
            if (vecs[i].n > 0) begin
                chk($sformatf("vec%0d_first_x", i), fx, vecs[i].fx);
                chk($sformatf("vec%0d_first_y", i), fy, vecs[i].fy);
                chk($sformatf("vec%0d_last_x", i), lx, vecs[i].lx);
                chk($sformatf("vec%0d_last_y", i), ly, vecs[i].ly);
            end
            @(negedge clk);
        end

        // Reset during the 3rd sample of a 5-sample sweep.
        drive(0, 0, 4096, 0, 0, {7{32'hA5A5_5A5A}}, {3{24'h123456}});
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_x", sx(), 2048);
        rst = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_last", int'(last_out), 0);
        chk("mid_rst_x", sx(), 0);
        chk_w("mid_rst_poly", poly_out, '0);
        chk("mid_rst_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", int'(in_ready), 1);
        @(negedge clk);
        run_poly(1024, 2048, 2048, 2048, 0, 0, cnt, fx, fy, lx, ly);
        chk("post_rst_count", cnt, 2);
        chk("post_rst_first_x", fx, 1024);
        chk("post_rst_first_y", fy, 2048);

        // Randomized boxes, shifts and backpressure.
        for (int r = 0; r < 20; r++) begin
            llx = int'($urandom_range(0, 6000)) - 3000;
            lly = int'($urandom_range(0, 6000)) - 3000;
            urx = llx + int'($urandom_range(0, 1500)) - 200;
            ury = lly + int'($urandom_range(0, 1500)) - 200;
            run_poly(llx, lly, urx, ury, int'($urandom_range(0, 3)), 1, cnt, fx, fy, lx, ly);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
